// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants for the pipelined rotation-mode CORDIC.
// Holds the arctangent table (32-bit turn fractions), the gain-compensation
// constant and a helper that rescales a table entry to the phase width.
package cordic_pkg;

    // 1/K for an unbounded CORDIC, 0.60725 in Q1.15.
    localparam logic [15:0] KSCALE = 16'h4DBA;

    // round(atan(2^-i) * 2^32 / (2*pi)), i = 0..15.
    localparam logic [31:0] ATAN_TAB32 [0:15] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D
    };

    // Table entry i rescaled to a phase word of phase_w bits.
    function automatic logic [31:0] atan_entry(input int unsigned i, input int unsigned phase_w);
        atan_entry = ATAN_TAB32[i[3:0]] >> (32 - phase_w);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation.
// Rotates (x, y) by +/-atan(2^-SHIFT) toward z = 0 and carries the valid
// bit and quadrant tag alongside. Holds everything while ena is low.
module cordic_stage #(
    parameter int          IW      = 19,
    parameter int          PHASE_W = 16,
    parameter int          SHIFT   = 0,
    parameter logic [31:0] ATAN    = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    input  logic [1:0]         q_in,
    input  logic [IW-1:0]      x_in,
    input  logic [IW-1:0]      y_in,
    input  logic [PHASE_W-1:0] z_in,
    output logic               out_valid,
    output logic [1:0]         q_out,
    output logic [IW-1:0]      x_out,
    output logic [IW-1:0]      y_out,
    output logic [PHASE_W-1:0] z_out
);

    localparam logic signed [PHASE_W-1:0] ATAN_S = ATAN[PHASE_W-1:0];

    logic signed [IW-1:0]      x_sh_s;
    logic signed [IW-1:0]      y_sh_s;
    logic signed [IW-1:0]      x_nx_s;
    logic signed [IW-1:0]      y_nx_s;
    logic signed [PHASE_W-1:0] z_nx_s;

    // Micro-rotation: direction chosen by the sign of the residual angle.
    always_comb begin
        x_sh_s = $signed(x_in) >>> SHIFT;
        y_sh_s = $signed(y_in) >>> SHIFT;
        if (z_in[PHASE_W-1]) begin
            x_nx_s = $signed(x_in) + y_sh_s;
            y_nx_s = $signed(y_in) - x_sh_s;
            z_nx_s = $signed(z_in) + ATAN_S;
        end else begin
            x_nx_s = $signed(x_in) - y_sh_s;
            y_nx_s = $signed(y_in) + x_sh_s;
            z_nx_s = $signed(z_in) - ATAN_S;
        end
    end

    // Stage register: advances only on enabled cycles, valid travels with data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q_out     <= 2'b00;
            x_out     <= {IW{1'b0}};
            y_out     <= {IW{1'b0}};
            z_out     <= {PHASE_W{1'b0}};
        end else if (ena) begin
            out_valid <= in_valid;
            q_out     <= q_in;
            x_out     <= x_nx_s;
            y_out     <= y_nx_s;
            z_out     <= z_nx_s;
        end
    end

endmodule

// File: rtl/cordic_rot_pipe.sv
// cordic_rot_pipe: fully pipelined rotation-mode CORDIC sin/cos generator.
// Fold/scale register -> STAGES micro-rotations -> quadrant map, guard-bit
// drop and saturation in the output register. Latency STAGES+2 enabled cycles.
// Optional macro CORDIC_ROUND_EN: round-half-up instead of truncation when
// the guard bits are dropped.
module cordic_rot_pipe
    import cordic_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 16,
    parameter int STAGES  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic [DATA_W-1:0]  amp_in,
    output logic               out_valid,
    output logic [DATA_W-1:0]  sin_out,
    output logic [DATA_W-1:0]  cos_out,
    output logic [PHASE_W-1:0] eps_out
);

    // One headroom MSB above DATA_W plus two guard LSBs.
    localparam int IW = DATA_W + 3;
    localparam int PW = DATA_W + 17;

    localparam logic signed [IW:0] SAT_MAX = $signed({{(IW+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [IW:0] SAT_MIN = $signed({{(IW+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}});
    localparam logic signed [IW:0] RND_HALF = $signed({{(IW-1){1'b0}}, 2'b10});

    // Drop guard bits (optionally rounding) and clamp to the DATA_W range.
    function automatic logic [DATA_W-1:0] sat_conv(input logic signed [IW:0] v);
        logic signed [IW:0] r;
`ifdef CORDIC_ROUND_EN
        r = (v + RND_HALF) >>> 2;
`else
        r = v >>> 2;
`endif
        if (r > SAT_MAX) begin
            sat_conv = SAT_MAX[DATA_W-1:0];
        end else if (r < SAT_MIN) begin
            sat_conv = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_conv = r[DATA_W-1:0];
        end
    endfunction

    logic signed [PW-1:0] amp_ext_s;
    logic signed [PW-1:0] k_ext_s;
    logic signed [PW-1:0] prod_s;
    logic [IW-1:0]        x_fold_s;
    logic                 unused_prod_s;

    logic                 v0_r;
    logic [1:0]           q0_r;
    logic [IW-1:0]        x0_r;
    logic [PHASE_W-1:0]   z0_r;

    logic                 v_s [0:STAGES];
    logic [1:0]           q_s [0:STAGES];
    logic [IW-1:0]        x_s [0:STAGES];
    logic [IW-1:0]        y_s [0:STAGES];
    logic [PHASE_W-1:0]   z_s [0:STAGES];

    logic signed [IW:0]   x_fin_s;
    logic signed [IW:0]   y_fin_s;
    logic signed [IW:0]   sin_pre_s;
    logic signed [IW:0]   cos_pre_s;

    // Pre-scale the amplitude by 1/K so the rotation gain lands at unity.
    always_comb begin
        amp_ext_s = $signed({{17{amp_in[DATA_W-1]}}, amp_in});
        k_ext_s   = $signed({{(DATA_W+1){1'b0}}, KSCALE});
        prod_s    = amp_ext_s * k_ext_s;
        x_fold_s  = {prod_s[DATA_W+15:15], 2'b00};
    end

    assign unused_prod_s = ^{prod_s[PW-1], prod_s[14:0]};

    // Fold register: split quadrant from the in-quadrant angle, load x0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_r <= 1'b0;
            q0_r <= 2'b00;
            x0_r <= {IW{1'b0}};
            z0_r <= {PHASE_W{1'b0}};
        end else if (ena) begin
            v0_r <= in_valid;
            q0_r <= phase_in[PHASE_W-1 -: 2];
            x0_r <= x_fold_s;
            z0_r <= {2'b00, phase_in[PHASE_W-3:0]};
        end
    end

    assign v_s[0] = v0_r;
    assign q_s[0] = q0_r;
    assign x_s[0] = x0_r;
    assign y_s[0] = {IW{1'b0}};
    assign z_s[0] = z0_r;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        cordic_stage #(
            .IW      (IW),
            .PHASE_W (PHASE_W),
            .SHIFT   (i),
            .ATAN    (atan_entry(i, PHASE_W))
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena       (ena),
            .in_valid  (v_s[i]),
            .q_in      (q_s[i]),
            .x_in      (x_s[i]),
            .y_in      (y_s[i]),
            .z_in      (z_s[i]),
            .out_valid (v_s[i+1]),
            .q_out     (q_s[i+1]),
            .x_out     (x_s[i+1]),
            .y_out     (y_s[i+1]),
            .z_out     (z_s[i+1])
        );
    end

    // Quadrant map, done one bit wider so negation never overflows.
    always_comb begin
        x_fin_s = $signed({x_s[STAGES][IW-1], x_s[STAGES]});
        y_fin_s = $signed({y_s[STAGES][IW-1], y_s[STAGES]});
        case (q_s[STAGES])
            2'b00: begin
                sin_pre_s = y_fin_s;
                cos_pre_s = x_fin_s;
            end
            2'b01: begin
                sin_pre_s = x_fin_s;
                cos_pre_s = -y_fin_s;
            end
            2'b10: begin
                sin_pre_s = -y_fin_s;
                cos_pre_s = -x_fin_s;
            end
            2'b11: begin
                sin_pre_s = -x_fin_s;
                cos_pre_s = y_fin_s;
            end
            default: begin
                sin_pre_s = y_fin_s;
                cos_pre_s = x_fin_s;
            end
        endcase
    end

    // Output register: updates on every enabled cycle, valid or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sin_out   <= {DATA_W{1'b0}};
            cos_out   <= {DATA_W{1'b0}};
            eps_out   <= {PHASE_W{1'b0}};
        end else if (ena) begin
            out_valid <= v_s[STAGES];
            sin_out   <= sat_conv(sin_pre_s);
            cos_out   <= sat_conv(cos_pre_s);
            eps_out   <= z_s[STAGES];
        end
    end

endmodule

// File: tb/tb_cordic_rot_pipe.sv
// tb_cordic_rot_pipe: scoreboard bench for cordic_rot_pipe (default build).
// The driver pushes hand-computed expectations when a sample is captured;
// a monitor pops and compares whenever the DUT presents out_valid.
module tb_cordic_rot_pipe;

    localparam int DATA_W   = 16;
    localparam int PHASE_W  = 16;
    localparam int STAGES   = 14;
    localparam int LAT      = STAGES + 2;
    localparam int TOL      = 4;
    localparam int EPS_TOL  = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ena = 1'b0;
    logic               in_valid = 1'b0;
    logic [PHASE_W-1:0] phase_in = 16'h0000;
    logic [DATA_W-1:0]  amp_in = 16'h0000;
    logic               out_valid;
    logic [DATA_W-1:0]  sin_out;
    logic [DATA_W-1:0]  cos_out;
    logic [PHASE_W-1:0] eps_out;

    cordic_rot_pipe #(.DATA_W(DATA_W), .PHASE_W(PHASE_W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .phase_in  (phase_in),
        .amp_in    (amp_in),
        .out_valid (out_valid),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .eps_out   (eps_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int exp_sin;
        int exp_cos;
        int stamp;
    } exp_t;

    typedef struct {
        logic [15:0] ph;
        logic [15:0] amp;
        int          es;
        int          ec;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs [0:8];
    int   n_checks = 0;
    int   n_fail = 0;
    int   en_cnt = 0;
    int   n_in = 0;
    int   n_out = 0;

    // Count enabled clock edges; latency is measured in these.
    always @(posedge clk) begin
        if (rst_n && ena) en_cnt <= en_cnt + 1;
    end

    task automatic check_int(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Present one valid sample; ena optionally random until an enabled edge takes it.
    task automatic issue(input vec_t v, input bit rand_ena);
        bit taken;
        taken = 1'b0;
        for (int k = 0; k < 64 && !taken; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            phase_in = v.ph;
            amp_in   = v.amp;
            ena      = rand_ena ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            taken = ena;
            #1;
        end
        if (taken) begin
            sb_q.push_back('{exp_sin: v.es, exp_cos: v.ec, stamp: en_cnt});
            n_in++;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: sample not accepted, got 0, want 1");
        end
    endtask

    // Invalid cycle carrying junk data, which must never surface.
    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0;
        phase_in = 16'($urandom);
        amp_in   = 16'($urandom);
        ena      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Run with ena high until every expected sample has been seen.
    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        ena      = 1'b1;
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check_int("drain_pending", sb_q.size(), 0, 0);
    endtask

    // Monitor: one look per enabled edge, compare against the scoreboard head.
    initial begin
        int   last_en;
        int   s;
        int   c;
        int   e;
        exp_t x;
        last_en = 0;
        forever begin
            @(negedge clk);
            if (rst_n && en_cnt != last_en) begin
                last_en = en_cnt;
                if (out_valid) begin
                    n_out++;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got out_valid=1 with nothing pending, want 0");
                    end else begin
                        x = sb_q.pop_front();
                        s = $signed(sin_out);
                        c = $signed(cos_out);
                        e = $signed(eps_out);
                        if (e < 0) e = -e;
                        check_int("latency", en_cnt - x.stamp + 1, LAT, 0);
                        check_int("sin", s, x.exp_sin, TOL);
                        check_int("cos", c, x.exp_cos, TOL);
                        check_int("eps_abs", e, 0, EPS_TOL);
                    end
                end
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Full scale here means amp * 0.607239 * 1.646760 ~ 0.99998 * amp.
        vecs[0] = '{16'h0000, 16'h7FFF,      0,  32766};
        vecs[1] = '{16'h4000, 16'h7FFF,  32766,      0};
        vecs[2] = '{16'h8000, 16'h7FFF,      0, -32766};
        vecs[3] = '{16'hC000, 16'h7FFF, -32766,      0};
        vecs[4] = '{16'h2000, 16'h4000,  11585,  11585};
        vecs[5] = '{16'h6000, 16'h4000,  11585, -11585};
        vecs[6] = '{16'h2000, 16'hC000, -11585, -11585};
        vecs[7] = '{16'h1555, 16'h7FFF,  16382,  28376};
        // Most-negative amplitude at 180 deg: cos clamps positive, never wraps.
        vecs[8] = '{16'h8000, 16'h8000,      0,  32767};

        // Reset state.
        #12;
        check_int("rst_out_valid", int'(out_valid), 0, 0);
        check_int("rst_sin", int'(sin_out), 0, 0);
        check_int("rst_cos", int'(cos_out), 0, 0);
        check_int("rst_eps", int'(eps_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) bubble();

        // Isolated pulses: exact latency and values for each vector.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i], 1'b0);
            drain();
        end

        // Back-to-back with bubbles and random stalls: order and count preserved.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 9; i++) begin
                issue(vecs[(i + r * 4) % 9], 1'b1);
                if (((i + r) % 4) == 3) bubble();
            end
        end
        drain();
        check_int("count_in_out", n_out, n_in, 0);

        // Reset mid-stream: in-flight samples vanish, outputs clear at once.
        for (int i = 0; i < 5; i++) issue(vecs[i], 1'b0);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_int("midrst_out_valid", int'(out_valid), 0, 0);
        check_int("midrst_sin", int'(sin_out), 0, 0);
        check_int("midrst_cos", int'(cos_out), 0, 0);
        check_int("midrst_eps", int'(eps_out), 0, 0);
        n_in = n_in - sb_q.size();
        sb_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (24) bubble();
        issue(vecs[4], 1'b0);
        drain();
        check_int("count_after_rst", n_out, n_in, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_rot_pipe.md
Name: cordic_rot_pipe

Overview:
- Parametrised, fully pipelined rotation-mode CORDIC sin/cos generator with per-sample valid tagging, global stall, amplitude scaling and output saturation.
- Successor to the fixed 8-bit, 6-iteration phase-to-sin/cos generator. Same datapath role: feeds mixers and NCOs in the baseband chain.
- One sample accepted per enabled clock.

Parameters:
- DATA_W, 16: signed width of amp_in, sin_out and cos_out (8..24).
- PHASE_W, 16: unsigned phase width; full scale 2^PHASE_W equals one turn (2π) (8..24).
- STAGES, 14: CORDIC micro-rotations (4..16; must be ≤ PHASE_W).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- ena, in, 1: global clock enable. When low, every register holds, including the valid pipe.
- in_valid, in, 1: phase_in/amp_in qualify this cycle (sampled only when ena=1).
- phase_in, in, PHASE_W: phase, unsigned turn fraction.
- amp_in, in, DATA_W: signed amplitude, two's complement.
- out_valid, out, 1: outputs qualify this cycle.
- sin_out, out, DATA_W: amp·sin(phase), signed, saturated.
- cos_out, out, DATA_W: amp·cos(phase), signed, saturated.
- eps_out, out, PHASE_W: residual angle z after the final stage, signed.

Behaviour:
- Reset: every pipeline register and all outputs go to 0; out_valid=0.
- Latency: exactly STAGES+2 enabled cycles from in_valid to out_valid. Breakdown:
  - 1 fold/scale register.
  - STAGES iteration registers.
  - 1 output register.
- Throughput 1/cycle. Cycles with ena=0 do not count toward latency.
- Valid handling:
  - The valid bit travels alongside the data.
  - Invalid samples still propagate through the datapath (no gating), but out_valid=0 for them.
  - Output registers update on every enabled cycle regardless of valid.
- Internal width IW = DATA_W+3: 1 headroom MSB and 2 guard LSBs. Z width = PHASE_W signed.
- Fold stage:
  - q = phase_in[PHASE_W-1:PHASE_W-2].
  - z0 = phase_in with its top two bits cleared, so 0 ≤ z0 < quarter turn.
  - x0 = (amp_in · KSCALE) >>> 15, sign-extended to IW, then shifted left by 2 guard bits. KSCALE = 16'h4DBA (0.60725·2^15).
  - y0 = 0.
  - q is delayed STAGES+1 enabled cycles to align with the data.
- Stage i (i = 0..STAGES-1):
  - d = z[PHASE_W-1] ? -1 : +1.
  - x' = x − d·(y>>>i).
  - y' = y + d·(x>>>i).
  - z' = z − d·ATAN[i].
  - Shifts are arithmetic.
- Output map (per aligned q):
  - q=00: sin=y, cos=x.
  - q=01: sin=x, cos=−y.
  - q=10: sin=−y, cos=−x.
  - q=11: sin=−x, cos=y.
- Output conversion:
  - Drop the 2 guard LSBs (truncate toward −∞).
  - Then saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Negation of the most-negative value saturates to the max positive value.
- eps_out = final z, unmodified.
- Reset asserted mid-operation: the pipe is flushed, and no out_valid is produced for in-flight samples after reset release.
- amp_in = −2^(DATA_W−1) is legal; outputs saturate, never wrap.

Optional Feature:
- Macro CORDIC_ROUND_EN.
- Defined: output conversion adds 2'b10 (half LSB) before dropping the guard bits (round-half-up), then saturates.
- Undefined: plain truncation.
- Latency is identical in both builds.

Decomposition:
- Package cordic_pkg holds:
  - ATAN_TAB32[0:15], round(atan(2^−i)·2^32/2π): 20000000, 12E4051E, 09FB385B, 051111D4, 028B0D43, 0145D7E1, 00A2F61E, 00517C55, 0028BE53, 00145F2F, 000A2F98, 000517CC, 00028BE6, 000145F3, 0000A2FA, 0000517D (hex).
  - KSCALE.
  - Function atan_entry(i, PHASE_W), returning ATAN_TAB32[i] >> (32−PHASE_W).
- Sub-module cordic_stage (params IW, PHASE_W, SHIFT, ATAN): one registered micro-rotation with ena and valid. The top level instantiates it STAGES times in a generate loop.

Test Plan:
- amp=0x7FFF, phase=0x0000, one valid pulse: out_valid exactly 16 enabled cycles later; cos=32767±4, sin=0±4.
- amp=0x7FFF, phase=0x4000 / 0x8000 / 0xC000: (sin,cos) = (32767,0) / (0,−32767) / (−32767,0), each ±4.
- amp=0x4000, phase=0x2000: sin=cos=11585±4. Sweep 65536 phases, amp=0x7FFF: max abs error ≤ 6 LSB vs real model; no wrap.
- Back-to-back valids with ena toggling 1-0-1 pseudo-randomly: outputs in order, out_valid count = in_valid count, no extra or lost samples.
- amp=0x8000, phase=0x8000: cos saturates to 32767, sin=0±4. Repeat with CORDIC_ROUND_EN defined and undefined: results differ by ≤ 1 LSB.
- Stream of valids, rst_n low mid-stream for 1 cycle: all outputs 0 and out_valid=0 immediately. First out_valid comes 16 cycles after the first post-reset input.
